// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer: prints a hex word as a valid/ready ASCII character stream
// with optional "0x" prefix, CR/LF terminator, lowercase digits and leading-zero suppression.
module hex_ascii_streamer #(
    parameter int DATA_W      = 32,
    parameter int LOWERCASE   = 0,
    parameter int PREFIX_EN   = 1,
    parameter int TERM_EN     = 1,
    parameter int SUPPRESS_LZ = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              out_last,
    output logic              busy
);
    localparam int N  = DATA_W / 4;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGITS, CR, LF} state_t;

    state_t            state, state_n, first, after;
    logic [DATA_W-1:0] data, data_n;
    logic [IW-1:0]     idx, idx_n, start;
    logic [3:0]        nib;
    logic [7:0]        digit, char_n;
    logic              last_n, accept, adv;

    assign first     = PREFIX_EN != 0 ? PFX0 : DIGITS;
    assign after     = TERM_EN != 0 ? CR : IDLE;
    assign in_ready  = state == IDLE && !rst;
    assign out_valid = state != IDLE;
    assign busy      = out_valid;
    assign accept    = in_valid && in_ready;
    assign adv       = out_valid && out_ready;

    // Highest nonzero nibble wins; an all-zero word still prints its LS digit.
    always_comb begin
        start = SUPPRESS_LZ != 0 ? '0 : IW'(N - 1);
        if (SUPPRESS_LZ != 0)
            for (int i = 0; i < N; i++)
                if (in_data[4*i +: 4] != 4'h0) start = IW'(i);
    end

    always_comb begin
        state_n = state;
        data_n  = data;
        idx_n   = idx;
        case (state)
            IDLE:    if (accept) begin
                         state_n = first;
                         data_n  = in_data;
                         idx_n   = start;
                     end
            PFX0:    if (adv) state_n = PFX1;
            PFX1:    if (adv) state_n = DIGITS;
            DIGITS:  if (adv) begin
                         if (idx == '0) state_n = after;
                         else idx_n = idx - 1'b1;
                     end
            CR:      if (adv) state_n = LF;
            LF:      if (adv) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // The output character is registered from the next state so it holds while stalled.
        nib    = 4'(data_n >> {idx_n, 2'b00});
        digit  = nib < 4'd10 ? 8'h30 + 8'(nib) : (LOWERCASE != 0 ? 8'h57 : 8'h37) + 8'(nib);
        char_n = state_n == PFX0   ? 8'h30 :
                 state_n == PFX1   ? 8'h78 :
                 state_n == DIGITS ? digit :
                 state_n == CR     ? 8'h0D :
                 state_n == LF     ? 8'h0A : 8'h20;
        last_n = state_n == LF || (state_n == DIGITS && idx_n == '0 && TERM_EN == 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data     <= '0;
            idx      <= '0;
            out_char <= 8'h20;
            out_last <= 1'b0;
        end else begin
            state    <= state_n;
            data     <= data_n;
            idx      <= idx_n;
            out_char <= char_n;
            out_last <= last_n;
        end
    end
endmodule

// File: tb/tb_hex_ascii_streamer.sv
// tb_hex_ascii_streamer: three differently configured streamers driven with directed and
// random words, received frames compared against a string-level model of the printout.
module tb_hex_ascii_streamer;
    localparam int DW[3] = '{32, 16, 32};
    localparam int LC[3] = '{0, 1, 0};
    localparam int TE[3] = '{1, 0, 1};
    localparam int SZ[3] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ivld[3], ordy[3], irdy[3], ov[3], lst[3], bsy[3];
    logic [31:0] din[3];
    logic [7:0]  ch[3];

    int          total = 0, bad = 0;
    byte unsigned exp_q[$], got_c[$];
    bit          got_l[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hex_ascii_streamer #(
            .DATA_W(DW[g]), .LOWERCASE(LC[g]), .PREFIX_EN(1), .TERM_EN(TE[g]), .SUPPRESS_LZ(SZ[g])
        ) dut (
            .clk(clk), .rst(rst),
            .in_valid(ivld[g]), .in_ready(irdy[g]), .in_data(din[g][DW[g]-1:0]),
            .out_valid(ov[g]), .out_ready(ordy[g]), .out_char(ch[g]), .out_last(lst[g]),
            .busy(bsy[g])
        );
    end

    // Expected printout: "0x", hex digits MS first (optionally without leading zeros), CR LF.
    task automatic build_exp(input int k, input logic [31:0] w);
        int nd, v;
        exp_q.delete();
        nd = DW[k] / 4;
        if (SZ[k] != 0) begin
            nd = 1;
            for (int i = 0; i < DW[k] / 4; i++) if (((w >> (4 * i)) & 32'hF) != 0) nd = i + 1;
        end
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
        for (int i = nd - 1; i >= 0; i--) begin
            v = int'((w >> (4 * i)) & 32'hF);
            exp_q.push_back(8'(v < 10 ? 48 + v : (LC[k] != 0 ? 97 : 65) + v - 10));
        end
        if (TE[k] != 0) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // Called and returns at posedge+1. hold keeps in_valid high with changing data during the frame;
    // abort_n > 0 stops after that many characters without finishing the frame.
    task automatic frame(input int k, input logic [31:0] w, input bit rnd, input bit hold,
                         input int abort_n, input string nm);
        bit acc, done, stall;
        logic [7:0] held_c;
        logic held_l;
        int t, cyc;
        build_exp(k, w);
        got_c.delete();
        got_l.delete();
        din[k] = w; ivld[k] = 1'b1; ordy[k] = 1'b1;
        acc = 1'b0; t = 0;
        while (!acc && t < 20) begin
            @(negedge clk);
            acc = irdy[k];
            @(posedge clk); #1;
            t++;
        end
        ivld[k] = hold;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL %s accept: in_ready=0 for 20 cycles, required 1", nm);
            return;
        end
        total++;
        if (ov[k] !== 1'b1 || bsy[k] !== 1'b1 || ch[k] !== exp_q[0]) begin
            bad++;
            $display("FAIL %s first: valid=%b busy=%b char=%h, required 1 1 %h", nm, ov[k], bsy[k], ch[k], exp_q[0]);
        end
        done = 1'b0; stall = 1'b0; cyc = 0; held_c = 8'h0; held_l = 1'b0;
        while (!done && cyc < 400) begin
            if (rnd) ordy[k] = 1'($urandom);
            if (hold) din[k] = $urandom;
            @(negedge clk);
            cyc++;
            if (hold) begin
                total++;
                if (irdy[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL %s gate: in_ready=%b while busy, required 0", nm, irdy[k]);
                end
            end
            if (stall) begin
                total++;
                if (ch[k] !== held_c || lst[k] !== held_l) begin
                    bad++;
                    $display("FAIL %s stall: char=%h last=%b, required %h %b", nm, ch[k], lst[k], held_c, held_l);
                end
            end
            stall = ov[k] && !ordy[k];
            held_c = ch[k];
            held_l = lst[k];
            if (ov[k] && ordy[k]) begin
                got_c.push_back(ch[k]);
                got_l.push_back(lst[k]);
                done = lst[k] || (abort_n > 0 && got_c.size() == abort_n);
            end
            @(posedge clk); #1;
        end
        ordy[k] = 1'b1;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: got %0d chars, required %0d", nm, got_c.size(), exp_q.size());
        end
        if (abort_n == 0) begin
            total++;
            if (got_c.size() != exp_q.size()) begin
                bad++;
                $display("FAIL %s length: got %0d, required %0d", nm, got_c.size(), exp_q.size());
            end
        end
        for (int i = 0; i < got_c.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_c[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL %s char%0d: got %h last=%b, required %h last=%b", nm, i, got_c[i], got_l[i],
                         exp_q[i], i == exp_q.size() - 1);
            end
        end
        if (abort_n == 0 && !rnd) begin
            total++;
            if (cyc != exp_q.size()) begin
                bad++;
                $display("FAIL %s rate: %0d cycles, required %0d", nm, cyc, exp_q.size());
            end
        end
        if (abort_n == 0) begin
            total++;
            if (ov[k] !== 1'b0 || bsy[k] !== 1'b0 || irdy[k] !== 1'b1) begin
                bad++;
                $display("FAIL %s end: valid=%b busy=%b in_ready=%b, required 0 0 1", nm, ov[k], bsy[k], irdy[k]);
            end
        end
    endtask

    task automatic check_idle(input string nm, input logic rdy);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ov[k] !== 1'b0 || bsy[k] !== 1'b0 || ch[k] !== 8'h20 || lst[k] !== 1'b0 || irdy[k] !== rdy) begin
                bad++;
                $display("FAIL %s dut%0d: valid=%b busy=%b char=%h last=%b in_ready=%b, required 0 0 20 0 %b",
                         nm, k, ov[k], bsy[k], ch[k], lst[k], irdy[k], rdy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle("reset", 1'b0);
        rst = 1'b0;
        #1 check_idle("reset_release", 1'b1);
    endtask

    task automatic test_defaults();
        frame(0, 32'hDEADBEEF, 0, 0, 0, "t1_deadbeef");
    endtask

    task automatic test_lowercase();
        frame(1, 32'h000000AF, 0, 0, 0, "t2_00af");
    endtask

    task automatic test_suppress();
        frame(2, 32'h0, 0, 0, 0, "t3_zero");
        frame(2, 32'h00000A10, 0, 0, 0, "t3_a10");
        frame(2, 32'hF0000000, 0, 0, 0, "t3_msnib");
    endtask

    task automatic test_backpressure();
        frame(0, 32'h12345678, 1, 0, 0, "t4_bp");
        frame(1, 32'h0000C0DE, 1, 0, 0, "t4_bp_lc");
        frame(2, 32'h00000007, 1, 0, 0, "t4_bp_lz");
    endtask

    task automatic test_input_gating();
        frame(0, 32'hA5A5A5A5, 0, 1, 0, "t5_hold");
        frame(0, 32'h0BADF00D, 0, 0, 0, "t5_next");
    endtask

    task automatic test_reset_mid();
        frame(0, 32'hCAFEF00D, 0, 0, 4, "t6_pre");
        rst = 1'b1;
        @(posedge clk);
        #1 check_idle("t6_reset", 1'b0);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1 check_idle("t6_quiet", 1'b1);
        end
        frame(0, 32'h00000001, 0, 0, 0, "t6_after");
    endtask

    task automatic test_random();
        int k;
        logic [31:0] w;
        for (int n = 0; n < 12; n++) begin
            k = int'($urandom_range(0, 2));
            w = $urandom >> $urandom_range(0, 31);
            frame(k, w, 1'($urandom), 0, 0, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            ivld[k] = 1'b0;
            ordy[k] = 1'b1;
            din[k] = '0;
        end
        test_reset();
        test_defaults();
        test_lowercase();
        test_suppress();
        test_backpressure();
        test_input_gating();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
